// File: rtl/bsg_two_fifo_w58.sv
// Two-entry ready/valid FIFO with registered full/empty flags and no bypass path.
// ready_o and v_o are purely registered, so neither depends combinationally on v_i or yumi_i.
module bsg_two_fifo_w58 #(
    parameter int width_p = 58
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o
);

    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [width_p-1:0] mem_q [2];

    logic enq, deq;

    // A yumi with nothing held is dropped so the pointers cannot drift.
    assign enq = v_i & ~full_q;
    assign deq = yumi_i & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q ^ enq;
        rptr_d  = rptr_q ^ deq;
        full_d  = full_q;
        empty_d = empty_q;
        if (enq && !deq) begin
            empty_d = 1'b0;
            full_d  = ~empty_q;
        end else if (deq && !enq) begin
            full_d  = 1'b0;
            empty_d = ~full_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Payload storage is intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;
    assign data_o  = mem_q[rptr_q];
    assign count_o = {full_q, ~full_q & ~empty_q};

endmodule
